// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one wait-stated data-memory port between the CPU
// MEM stage (C) and a host/debug loader (H); one access runs IDLE -> ACC -> ACK.
module dmem_arbiter #(
  parameter int AW       = 19,
  parameter int DW       = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_c_req,
  input  logic          i_c_we,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  output logic [DW-1:0] o_c_rdata,
  output logic          o_c_ack,
  output logic          o_c_stall,
  input  logic          i_h_req,
  input  logic          i_h_we,
  input  logic [AW-1:0] i_h_addr,
  input  logic [DW-1:0] i_h_wdata,
  output logic [DW-1:0] o_h_rdata,
  output logic          o_h_ack,
  output logic          o_h_stall,
  output logic          o_mem_wr,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_dout,
  input  logic [DW-1:0] i_mem_din,
  output logic          o_busy
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_last_h;
  logic          r_gnt_h;
  logic          r_we;
  logic          r_busy;
  logic          r_mem_wr;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_dout;
  logic          r_c_ack;
  logic          r_h_ack;
  logic [DW-1:0] r_c_rdata;
  logic [DW-1:0] r_h_rdata;
  logic          w_grant;
  logic          w_pick_h;
  logic          w_acc_done;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and arbitration; on a tie the port that did not win last time is picked
  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_pick_h   = 1'b0;
    w_acc_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_c_req || i_h_req) begin
          w_grant  = 1'b1;
          w_pick_h = i_h_req && (!i_c_req || !r_last_h);
          w_next   = ST_ACC;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (r_cnt == 4'd0) begin
          w_acc_done = 1'b1;
          w_next     = ST_ACK;
        end else begin
          w_next = ST_ACC;
        end
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Transaction latch, memory strobes, acks and read-data capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= 4'd0;
      r_last_h   <= 1'b1;
      r_gnt_h    <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_dout <= '0;
      r_c_ack    <= 1'b0;
      r_h_ack    <= 1'b0;
      r_c_rdata  <= '0;
      r_h_rdata  <= '0;
    end else begin
      r_busy   <= (w_next != ST_IDLE);
      r_c_ack  <= 1'b0;
      r_h_ack  <= 1'b0;
      r_mem_wr <= 1'b0;
      if (w_grant) begin
        r_gnt_h    <= w_pick_h;
        r_last_h   <= w_pick_h;
        r_we       <= w_pick_h ? i_h_we : i_c_we;
        r_mem_wr   <= w_pick_h ? i_h_we : i_c_we;
        r_mem_addr <= w_pick_h ? i_h_addr : i_c_addr;
        r_mem_dout <= w_pick_h ? i_h_wdata : i_c_wdata;
        r_cnt      <= CNT_INIT;
      end else if (w_acc_done) begin
        r_mem_addr <= '0;
        r_mem_dout <= '0;
        r_c_ack    <= !r_gnt_h;
        r_h_ack    <= r_gnt_h;
        // Read data is sampled on the edge that closes the wait window
        if (!r_we && r_gnt_h) begin
          r_h_rdata <= i_mem_din;
        end else if (!r_we) begin
          r_c_rdata <= i_mem_din;
        end
      end else if (r_state == ST_ACC) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign o_c_rdata  = r_c_rdata;
  assign o_c_ack    = r_c_ack;
  assign o_c_stall  = i_c_req & ~r_c_ack;
  assign o_h_rdata  = r_h_rdata;
  assign o_h_ack    = r_h_ack;
  assign o_h_stall  = i_h_req & ~r_h_ack;
  assign o_mem_wr   = r_mem_wr;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_dout = r_mem_dout;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a timeline reference model (grant edge,
// ack at grant+WAIT, next grant at grant+WAIT+2) compared every cycle, plus scenario checks.
module tb_dmem_arbiter;
  localparam int AW   = 19;
  localparam int DW   = 32;
  localparam int WAIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, h_req, h_we;
  logic [AW-1:0] c_addr, h_addr;
  logic [DW-1:0] c_wdata, h_wdata, mem_din;
  logic [DW-1:0] c_rdata, h_rdata, mem_dout;
  logic          c_ack, h_ack, c_stall, h_stall, mem_wr, busy;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(WAIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_rdata(c_rdata), .o_c_ack(c_ack), .o_c_stall(c_stall),
    .i_h_req(h_req), .i_h_we(h_we), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
    .o_h_rdata(h_rdata), .o_h_ack(h_ack), .o_h_stall(h_stall),
    .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_dout(mem_dout),
    .i_mem_din(mem_din), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int            m_n = 0;        // index of the most recent rising edge
  int            m_g = 0;        // edge at which the latest access was granted
  bit            m_have = 1'b0;  // an access has been granted since reset
  bit            m_win_h = 1'b0, m_we = 1'b0, m_last_h = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_c_rdata = '0, m_h_rdata = '0;
  int            e_next, d;
  bit            can_grant, pick_h, in_acc, in_ack, exp_c_ack, exp_h_ack;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_dout;
  logic [120:0]  exp_vec, dut_vec;

  always_comb begin
    e_next    = m_n + 1;
    can_grant = !m_have || (e_next - m_g >= WAIT + 2);
    if (c_req && h_req) pick_h = !m_last_h;
    else                pick_h = h_req;
  end

  always @(posedge clk) begin
    m_n <= e_next;
    if (rst) begin
      m_have    <= 1'b0;
      m_last_h  <= 1'b1;
      m_c_rdata <= '0;
      m_h_rdata <= '0;
    end else begin
      if (can_grant && (c_req || h_req)) begin
        m_have   <= 1'b1;
        m_g      <= e_next;
        m_win_h  <= pick_h;
        m_last_h <= pick_h;
        m_we     <= pick_h ? h_we : c_we;
        m_addr   <= pick_h ? h_addr : c_addr;
        m_wdata  <= pick_h ? h_wdata : c_wdata;
      end
      if (m_have && (e_next - m_g == WAIT) && !m_we) begin
        if (m_win_h) m_h_rdata <= mem_din;
        else         m_c_rdata <= mem_din;
      end
    end
  end

  always_comb begin
    d         = m_n - m_g;
    in_acc    = m_have && (d >= 0) && (d < WAIT);
    in_ack    = m_have && (d == WAIT);
    exp_c_ack = in_ack && !m_win_h;
    exp_h_ack = in_ack && m_win_h;
    exp_addr  = in_acc ? m_addr : {AW{1'b0}};
    exp_dout  = in_acc ? m_wdata : {DW{1'b0}};
    exp_vec   = {in_acc || in_ack, in_acc && (d == 0) && m_we, exp_addr, exp_dout,
                 exp_c_ack, exp_h_ack, c_req && !exp_c_ack, h_req && !exp_h_ack,
                 m_c_rdata, m_h_rdata};
  end

  assign dut_vec = {busy, mem_wr, mem_addr, mem_dout, c_ack, h_ack, c_stall, h_stall,
                    c_rdata, h_rdata};

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; c_req = 1'b0; h_req = 1'b0; c_we = 1'b1; h_we = 1'b1;
    c_addr = AW'($urandom); h_addr = AW'($urandom);
    c_wdata = $urandom; h_wdata = $urandom; mem_din = $urandom;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset: got %h expected all zero", dut_vec);
    end
    rst = 1'b0;
  endtask

  task automatic test_c_read();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 19'h00010; mem_din = $urandom;
    for (int k = 0; k <= WAIT + 1; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL c_read cyc %0d: got %h expected %h", k, dut_vec, exp_vec);
      end
      if (k < WAIT) begin
        checks++;
        if (c_stall !== 1'b1 || mem_addr !== 19'h00010) begin
          errors++; $display("FAIL c_read_acc cyc %0d: stall %b addr %h expected 1 00010", k, c_stall, mem_addr);
        end
      end else if (k == WAIT) begin
        checks++;
        if (c_ack !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL c_read_ack: ack %b rdata %h expected 1 deadbeef", c_ack, c_rdata);
        end
        c_req = 1'b0;
      end else begin
        c_req = 1'b0;
      end
      mem_din = (k == WAIT - 1) ? 32'hDEADBEEF : $urandom;
    end
  endtask

  task automatic test_h_write();
    int wr_cnt = 0, addr_cnt = 0, ack_k = -1;
    @(negedge clk);
    h_req = 1'b1; h_we = 1'b1; h_addr = 19'h7FFFF; h_wdata = 32'h12345678;
    for (int k = 0; k <= WAIT + 1; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL h_write cyc %0d: got %h expected %h", k, dut_vec, exp_vec);
      end
      if (mem_wr === 1'b1) wr_cnt++;
      if (mem_addr === 19'h7FFFF && mem_dout === 32'h12345678) addr_cnt++;
      if (h_ack === 1'b1) ack_k = k;
      if (exp_h_ack) h_req = 1'b0;
      mem_din = $urandom;
    end
    checks++;
    if (wr_cnt != 1 || addr_cnt != WAIT || ack_k != WAIT || h_rdata !== 32'h0) begin
      errors++;
      $display("FAIL h_write_summary: wr %0d addr %0d ack_at %0d rdata %h expected 1 %0d %0d 0",
               wr_cnt, addr_cnt, ack_k, h_rdata, WAIT, WAIT);
    end
  endtask

  task automatic test_simultaneous();
    int c_left = 1, h_left = 1;
    bit order[$];
    int when[$];
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = AW'($urandom);
    h_req = 1'b1; h_we = 1'b1; h_addr = AW'($urandom); h_wdata = $urandom;
    for (int k = 0; k < 4 * (WAIT + 2) + 4; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL simul cyc %0d: got %h expected %h", k, dut_vec, exp_vec);
      end
      if (c_ack === 1'b1) begin order.push_back(1'b0); when.push_back(k); end
      if (h_ack === 1'b1) begin order.push_back(1'b1); when.push_back(k); end
      mem_din = $urandom;
      if (exp_c_ack) c_req = 1'b0;
      else if (!c_req && c_left > 0) begin
        c_req = 1'b1; c_left--; c_we = 1'(($urandom)); c_addr = AW'($urandom); c_wdata = $urandom;
      end
      if (exp_h_ack) h_req = 1'b0;
      else if (!h_req && h_left > 0) begin
        h_req = 1'b1; h_left--; h_we = 1'(($urandom)); h_addr = AW'($urandom); h_wdata = $urandom;
      end
    end
    checks++;
    if (order.size() != 4) begin
      errors++; $display("FAIL simul_count: got %0d acks expected 4", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] !== 1'(i % 2)) begin
        errors++; $display("FAIL simul_order %0d: got port %0d expected %0d", i, order[i], i % 2);
      end
      if (i > 0) begin
        checks++;
        if (when[i] - when[i-1] != WAIT + 2) begin
          errors++; $display("FAIL simul_spacing %0d: got %0d expected %0d", i, when[i] - when[i-1], WAIT + 2);
        end
      end
    end
  endtask

  task automatic test_withdraw();
    int n_ack = 0;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = AW'($urandom); mem_din = $urandom;
    for (int k = 0; k <= WAIT + 2; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL withdraw cyc %0d: got %h expected %h", k, dut_vec, exp_vec);
      end
      if (c_ack === 1'b1) n_ack++;
      if (k == 0) begin c_req = 1'b0; c_we = 1'b1; c_addr = ~c_addr; end
      mem_din = $urandom;
    end
    checks++;
    if (n_ack != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL withdraw_summary: acks %0d busy %b expected 1 0", n_ack, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit first_seen = 1'b0, first_h = 1'b0;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = AW'($urandom); c_wdata = $urandom;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL rst_mid acc %0d: got %h expected %h", k, dut_vec, exp_vec);
      end
    end
    rst = 1'b1; c_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_wr, mem_addr, busy, c_ack, h_ack} !== '0) begin
      errors++; $display("FAIL rst_mid_abort: wr %b addr %h busy %b acks %b%b expected all 0",
                         mem_wr, mem_addr, busy, c_ack, h_ack);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL rst_mid idle %0d: got %h expected %h", k, dut_vec, exp_vec);
      end
    end
    c_req = 1'b1; c_we = 1'b0; h_req = 1'b1; h_we = 1'b0;
    for (int k = 0; k < 2 * (WAIT + 2) + 1; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL rst_mid tie %0d: got %h expected %h", k, dut_vec, exp_vec);
      end
      if (!first_seen && (c_ack === 1'b1 || h_ack === 1'b1)) begin
        first_seen = 1'b1; first_h = h_ack;
      end
      mem_din = $urandom;
      if (exp_c_ack) c_req = 1'b0;
      if (exp_h_ack) h_req = 1'b0;
    end
    checks++;
    if (!first_seen || first_h) begin
      errors++; $display("FAIL rst_mid_winner: seen %b h_first %b expected 1 0", first_seen, first_h);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = AW'($urandom); mem_din = 32'h11;
    for (int k = 0; k <= WAIT; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL b2b_a cyc %0d: got %h expected %h", k, dut_vec, exp_vec);
      end
      if (exp_c_ack) begin c_req = 1'b0; mem_din = $urandom; end
    end
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      checks++;
      if (c_rdata !== 32'h11 || busy !== 1'b0) begin
        errors++; $display("FAIL b2b_gap %0d: rdata %h busy %b expected 00000011 0", g, c_rdata, busy);
      end
      mem_din = $urandom;
    end
    c_req = 1'b1; c_addr = AW'($urandom); mem_din = 32'h22;
    for (int k = 0; k <= WAIT; k++) begin
      @(negedge clk);
      checks++;
      if (c_rdata !== ((k == WAIT) ? 32'h22 : 32'h11)) begin
        errors++; $display("FAIL b2b_b cyc %0d: rdata %h expected %h", k, c_rdata,
                           (k == WAIT) ? 32'h22 : 32'h11);
      end
      if (exp_c_ack) c_req = 1'b0;
    end
  endtask

  task automatic test_random();
    int c_gap = 0, h_gap = 1, n_acks = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", k, dut_vec, exp_vec);
      end
      if (c_ack === 1'b1 || h_ack === 1'b1) n_acks++;
      mem_din = $urandom;
      if (c_req && exp_c_ack) begin c_req = 1'b0; c_gap = $urandom_range(0, 3); end
      else if (!c_req) begin
        if (c_gap == 0) begin
          c_req = 1'b1; c_we = 1'($urandom); c_addr = AW'($urandom); c_wdata = $urandom;
        end else c_gap--;
      end
      if (h_req && exp_h_ack) begin h_req = 1'b0; h_gap = $urandom_range(0, 3); end
      else if (!h_req) begin
        if (h_gap == 0) begin
          h_req = 1'b1; h_we = 1'($urandom); h_addr = AW'($urandom); h_wdata = $urandom;
        end else h_gap--;
      end
    end
    c_req = 1'b0; h_req = 1'b0;
    for (int k = 0; k < 2 * (WAIT + 2); k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL random_drain %0d: got %h expected %h", k, dut_vec, exp_vec);
      end
    end
    checks++;
    if (n_acks < 400 / (WAIT + 2) / 2) begin
      errors++; $display("FAIL random_progress: got %0d acks expected at least %0d", n_acks, 400 / (WAIT + 2) / 2);
    end
  endtask

  initial begin
    test_reset();
    test_c_read();
    test_h_write();
    test_simultaneous();
    test_withdraw();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single external data-memory port between two requesters: the CPU MEM stage (port C) and a host/debug loader (port H).
- Runs each transaction as a sequenced access with a fixed, parameterised wait-state count.
- Returns read data with a one-cycle acknowledge pulse.
- Sits between the cpu data port and the board memory, and produces the stall the pipeline holds on while its access is pending.

Parameters:
- AW, 19: memory address width.
- DW, 32: data width.
- WAIT_CYC, 1: cycles the address is held on the memory before read data is sampled; legal range 1..15.

Ports:
- clk  in  1: clock, all state on rising edge.
- rst  in  1: synchronous, active-high reset.
- c_req  in  1: CPU request; held high until c_ack.
- c_we  in  1: CPU write enable (1 = write, 0 = read).
- c_addr  in  AW: CPU address.
- c_wdata  in  DW: CPU write data.
- c_rdata  out  DW: CPU read data.
- c_ack  out  1: CPU completion pulse.
- c_stall  out  1: c_req & ~c_ack, combinational.
- h_req, h_we, h_addr, h_wdata, h_rdata, h_ack: same as the c_* ports, for the host.
- mem_wr  out  1: memory write strobe.
- mem_addr  out  AW: memory address.
- mem_dout  out  DW: memory write data.
- mem_din  in  DW: memory read data.
- busy  out  1: high in any state other than IDLE.

Behaviour:
- Reset (synchronous): rst high at an edge forces the following.
  - state = IDLE.
  - mem_wr, mem_addr, mem_dout, c_ack, h_ack, c_rdata, h_rdata, busy all 0.
  - wait counter = 0.
  - last_grant = H, so C wins the first tie.
- Reset mid-transaction: the transaction is aborted. No ack is issued. mem_wr is low from the cycle after the reset edge.
- FSM states are IDLE, ACC and ACK.
- IDLE:
  - Neither req high: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both high: grant the port that is not last_grant (round-robin).
  - On grant: latch winner's we, addr and wdata; set last_grant = winner; load counter = WAIT_CYC-1; go to ACC.
- ACC:
  - mem_addr = latched addr for every ACC cycle.
  - mem_dout = latched wdata for every ACC cycle.
  - mem_wr = latched we only on the first ACC cycle (single write strobe).
  - Counter decrements each cycle. When counter == 0, go to ACK.
  - On that final edge, if the access is a read, capture mem_din into the winner's rdata register.
- ACK:
  - Winner's ack = 1 for exactly one cycle.
  - mem_wr, mem_addr and mem_dout return to 0.
  - Next state is IDLE.
- Latency: a request sampled in IDLE at edge t gives ack high in cycle t+WAIT_CYC+1.
- Throughput: one transaction per WAIT_CYC+2 cycles.
- rdata is valid during the ack cycle and held until that port's next read completes. Writes leave rdata unchanged.
- Requester dropping req mid-transaction: the transaction still completes and ack still pulses.
- Inputs changing after grant have no effect on the transaction in flight.
- req still high in the IDLE cycle after ack: treated as a new transaction. Requesters must deassert req in the ack cycle.
- Starvation freedom: with both ports continuously requesting, grants alternate C, H, C, H.
- The losing port's ack stays 0. Its c_stall / h_stall stays high while it waits.
- Only one of c_ack and h_ack is ever high in a given cycle.

Test Plan:
- Reset, then C read only:
  - Stimulus: WAIT_CYC=1; c_req=1, c_we=0, c_addr=0x00010; memory returns 0xDEADBEEF.
  - Response: mem_addr=0x00010 for 1 cycle; c_ack pulses 2 cycles after the req edge; c_rdata=0xDEADBEEF; mem_wr never high; c_stall high until ack.
- H write:
  - Stimulus: WAIT_CYC=3; h_we=1, h_addr=0x7FFFF, h_wdata=0x12345678.
  - Response: mem_addr held for 3 cycles; mem_wr high only on the first; h_ack 4 cycles after the req edge; h_rdata unchanged (0).
- Simultaneous requests:
  - Stimulus: c_req and h_req both held high for 4 transactions.
  - Response: grant order C, H, C, H; acks never overlap; spacing WAIT_CYC+2 cycles.
- Request withdrawn:
  - Stimulus: c_req dropped one cycle after grant.
  - Response: access completes, c_ack still pulses once, FSM returns to IDLE.
- Reset mid-ACC:
  - Stimulus: WAIT_CYC=4; rst asserted on the 2nd ACC cycle of a write.
  - Response: next cycle state IDLE, mem_wr=0, mem_addr=0, no ack; a subsequent simultaneous request is won by C.
- Back-to-back reads:
  - Stimulus: C reads A (data 0x11), then B (data 0x22).
  - Response: c_rdata=0x11 is held through the idle gap and becomes 0x22 only at the second ack.
